// File: rtl/nco_acq_ctrl_if.sv
// ----------------------------------------------------------------------------
// nco_acq_ctrl_if
// Bundle between the carrier-acquisition controller and its surroundings.
//   master : drives start/abort, the sweep window, dwell, lock indicator,
//            loop error and NCO valid; observes every controller output.
//   slave  : the controller itself (nco_acq_ctrl).
// Signals
//   start_i / abort_i      : start pulse, return-to-idle request
//   f_start_i/f_step_i/
//   f_stop_i               : sweep window (unsigned phase increments)
//   dwell_i                : cycles per step (0 behaves as 1)
//   lock_i / loop_err_i    : carrier-loop lock flag and signed correction
//   nco_valid_i            : NCO out_valid
//   nco_phi_inc_o, nco_freq_mod_o, nco_reset_n_o, nco_clken_o : NCO control
//   busy_o, locked_o, fail_o, step_cnt_o                       : status
// ----------------------------------------------------------------------------
interface nco_acq_ctrl_if #(
    parameter int PHI_W   = 30,
    parameter int DWELL_W = 16
);
    logic               start_i;
    logic               abort_i;
    logic [PHI_W-1:0]   f_start_i;
    logic [PHI_W-1:0]   f_step_i;
    logic [PHI_W-1:0]   f_stop_i;
    logic [DWELL_W-1:0] dwell_i;
    logic               lock_i;
    logic [PHI_W-1:0]   loop_err_i;
    logic               nco_valid_i;
    logic [PHI_W-1:0]   nco_phi_inc_o;
    logic [PHI_W-1:0]   nco_freq_mod_o;
    logic               nco_reset_n_o;
    logic               nco_clken_o;
    logic               busy_o;
    logic               locked_o;
    logic               fail_o;
    logic [7:0]         step_cnt_o;

    modport master (
        output start_i, abort_i, f_start_i, f_step_i, f_stop_i, dwell_i,
               lock_i, loop_err_i, nco_valid_i,
        input  nco_phi_inc_o, nco_freq_mod_o, nco_reset_n_o, nco_clken_o,
               busy_o, locked_o, fail_o, step_cnt_o
    );

    modport slave (
        input  start_i, abort_i, f_start_i, f_step_i, f_stop_i, dwell_i,
               lock_i, loop_err_i, nco_valid_i,
        output nco_phi_inc_o, nco_freq_mod_o, nco_reset_n_o, nco_clken_o,
               busy_o, locked_o, fail_o, step_cnt_o
    );
endinterface

// File: rtl/nco_acq_ctrl.sv
// ----------------------------------------------------------------------------
// nco_acq_ctrl
// Carrier-acquisition controller for the BPSK receive NCO. Resets and starts
// the NCO, sweeps its phase increment from f_start to f_stop in f_step
// increments, dwelling at each step for the carrier loop to report lock.
// While locked, the loop error is passed to the NCO frequency-modulation
// input; a sustained loss of lock resumes the dwell at the current step.
// Ports
//   clk    : system clock, rising edge
//   reset  : asynchronous active-high reset
//   bus    : nco_acq_ctrl_if slave modport (control, window, NCO, status)
// All outputs are driven straight from registers.
// ----------------------------------------------------------------------------
module nco_acq_ctrl #(
    parameter int PHI_W    = 30,
    parameter int DWELL_W  = 16,
    parameter int RST_CYC  = 7,
    parameter int VALID_TO = 64,
    parameter int LOCK_CNT = 8
) (
    input  logic          clk,
    input  logic          reset,
    nco_acq_ctrl_if.slave bus
);

    localparam int RST_W = $clog2(RST_CYC + 1);
    localparam int VTO_W = $clog2(VALID_TO + 1);
    localparam int LCK_W = $clog2(LOCK_CNT + 1);

    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYC - 1);
    localparam logic [VTO_W-1:0] VTO_LAST = VTO_W'(VALID_TO - 1);
    localparam logic [LCK_W-1:0] LCK_FULL = LCK_W'(LOCK_CNT);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RST    = 3'd1,
        S_WAIT_V = 3'd2,
        S_DWELL  = 3'd3,
        S_STEP   = 3'd4,
        S_LOCKED = 3'd5,
        S_FAIL   = 3'd6
    } state_t;

    state_t             state_q,       state_d;
    logic [PHI_W-1:0]   phi_inc_q,     phi_inc_d;
    logic [PHI_W-1:0]   freq_mod_q,    freq_mod_d;
    logic               nco_reset_n_q, nco_reset_n_d;
    logic               clken_q,       clken_d;
    logic               busy_q,        busy_d;
    logic               locked_q,      locked_d;
    logic               fail_q,        fail_d;
    logic [7:0]         step_cnt_q,    step_cnt_d;
    logic [PHI_W-1:0]   f_step_q,      f_step_d;
    logic [PHI_W-1:0]   f_stop_q,      f_stop_d;
    logic [DWELL_W-1:0] dwell_q,       dwell_d;
    logic [DWELL_W-1:0] dwell_cnt_q,   dwell_cnt_d;
    logic [LCK_W-1:0]   lock_cnt_q,    lock_cnt_d;
    logic [RST_W-1:0]   rst_cnt_q,     rst_cnt_d;
    logic [VTO_W-1:0]   vto_cnt_q,     vto_cnt_d;

    logic [PHI_W:0]     step_sum_s;
    logic               step_over_s;
    logic [DWELL_W-1:0] dwell_nxt_s;
    logic [LCK_W-1:0]   lock_nxt_s;
    logic [LCK_W-1:0]   loss_nxt_s;
    logic               start_ok_s;

    // Candidate step computed one bit wider so a wrap past 2^PHI_W is seen
    // as a carry instead of silently landing inside the window.
    assign step_sum_s  = {1'b0, phi_inc_q} + {1'b0, f_step_q};
    assign step_over_s = step_sum_s[PHI_W] || (step_sum_s[PHI_W-1:0] > f_stop_q);
    assign dwell_nxt_s = dwell_cnt_q + DWELL_W'(1'b1);
    // lock_cnt_q counts consecutive highs in DWELL and consecutive lows in LOCKED.
    assign lock_nxt_s  = bus.lock_i ? (lock_cnt_q + LCK_W'(1'b1)) : LCK_W'(1'b0);
    assign loss_nxt_s  = bus.lock_i ? LCK_W'(1'b0) : (lock_cnt_q + LCK_W'(1'b1));
    // start is honoured only where no acquisition is in flight.
    assign start_ok_s  = bus.start_i && ((state_q == S_IDLE) ||
                                         (state_q == S_LOCKED) ||
                                         (state_q == S_FAIL));

    // Next-state and next-output logic; outputs are registered from the _d values.
    always_comb begin
        state_d       = state_q;
        phi_inc_d     = phi_inc_q;
        freq_mod_d    = {PHI_W{1'b0}};
        nco_reset_n_d = nco_reset_n_q;
        clken_d       = clken_q;
        busy_d        = busy_q;
        locked_d      = locked_q;
        fail_d        = fail_q;
        step_cnt_d    = step_cnt_q;
        f_step_d      = f_step_q;
        f_stop_d      = f_stop_q;
        dwell_d       = dwell_q;
        dwell_cnt_d   = dwell_cnt_q;
        lock_cnt_d    = lock_cnt_q;
        rst_cnt_d     = rst_cnt_q;
        vto_cnt_d     = vto_cnt_q;

        if (bus.abort_i) begin
            // Abort wins over everything, including a coincident start.
            state_d       = S_IDLE;
            phi_inc_d     = {PHI_W{1'b0}};
            nco_reset_n_d = 1'b0;
            clken_d       = 1'b0;
            busy_d        = 1'b0;
            locked_d      = 1'b0;
            fail_d        = 1'b0;
            step_cnt_d    = 8'd0;
            dwell_cnt_d   = {DWELL_W{1'b0}};
            lock_cnt_d    = {LCK_W{1'b0}};
            rst_cnt_d     = {RST_W{1'b0}};
            vto_cnt_d     = {VTO_W{1'b0}};
        end else if (start_ok_s) begin
            state_d       = S_RST;
            phi_inc_d     = bus.f_start_i;
            nco_reset_n_d = 1'b0;
            clken_d       = 1'b1;
            busy_d        = 1'b1;
            locked_d      = 1'b0;
            fail_d        = 1'b0;
            step_cnt_d    = 8'd0;
            f_step_d      = bus.f_step_i;
            f_stop_d      = bus.f_stop_i;
            // Store the effective dwell so a zero request means one cycle.
            dwell_d       = (bus.dwell_i == {DWELL_W{1'b0}}) ? DWELL_W'(1'b1) : bus.dwell_i;
            rst_cnt_d     = {RST_W{1'b0}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    nco_reset_n_d = 1'b0;
                    clken_d       = 1'b0;
                end
                S_RST: begin
                    if (rst_cnt_q == RST_LAST) begin
                        state_d       = S_WAIT_V;
                        nco_reset_n_d = 1'b1;
                        vto_cnt_d     = {VTO_W{1'b0}};
                    end else begin
                        rst_cnt_d     = rst_cnt_q + RST_W'(1'b1);
                    end
                end
                S_WAIT_V: begin
                    if (bus.nco_valid_i) begin
                        state_d     = S_DWELL;
                        dwell_cnt_d = {DWELL_W{1'b0}};
                        lock_cnt_d  = {LCK_W{1'b0}};
                    end else if (vto_cnt_q == VTO_LAST) begin
                        state_d     = S_FAIL;
                        fail_d      = 1'b1;
                        busy_d      = 1'b0;
                        clken_d     = 1'b0;
                    end else begin
                        vto_cnt_d   = vto_cnt_q + VTO_W'(1'b1);
                    end
                end
                S_DWELL: begin
                    dwell_cnt_d = dwell_nxt_s;
                    lock_cnt_d  = lock_nxt_s;
                    // Lock is tested first so it wins over an expiring dwell.
                    if (lock_nxt_s == LCK_FULL) begin
                        state_d    = S_LOCKED;
                        locked_d   = 1'b1;
                        busy_d     = 1'b0;
                        lock_cnt_d = {LCK_W{1'b0}};
                        freq_mod_d = bus.loop_err_i;
                    end else if (dwell_nxt_s == dwell_q) begin
                        state_d    = S_STEP;
                    end else begin
                        state_d    = S_DWELL;
                    end
                end
                S_STEP: begin
                    if (step_over_s) begin
                        // Window exhausted: keep the last legal increment.
                        state_d     = S_FAIL;
                        fail_d      = 1'b1;
                        busy_d      = 1'b0;
                        clken_d     = 1'b0;
                    end else begin
                        // NCO keeps running; only the increment changes.
                        state_d     = S_DWELL;
                        phi_inc_d   = step_sum_s[PHI_W-1:0];
                        step_cnt_d  = (step_cnt_q == 8'hFF) ? step_cnt_q : (step_cnt_q + 8'd1);
                        dwell_cnt_d = {DWELL_W{1'b0}};
                        lock_cnt_d  = {LCK_W{1'b0}};
                    end
                end
                S_LOCKED: begin
                    lock_cnt_d = loss_nxt_s;
                    if (loss_nxt_s == LCK_FULL) begin
                        // Lock lost: resume dwelling at the same increment.
                        state_d     = S_DWELL;
                        locked_d    = 1'b0;
                        busy_d      = 1'b1;
                        dwell_cnt_d = {DWELL_W{1'b0}};
                        lock_cnt_d  = {LCK_W{1'b0}};
                    end else begin
                        freq_mod_d  = bus.loop_err_i;
                    end
                end
                S_FAIL: begin
                    fail_d        = 1'b1;
                    busy_d        = 1'b0;
                    clken_d       = 1'b0;
                    nco_reset_n_d = 1'b1;
                end
                default: begin
                    state_d       = S_IDLE;
                    phi_inc_d     = {PHI_W{1'b0}};
                    nco_reset_n_d = 1'b0;
                    clken_d       = 1'b0;
                    busy_d        = 1'b0;
                    locked_d      = 1'b0;
                    fail_d        = 1'b0;
                    step_cnt_d    = 8'd0;
                end
            endcase
        end
    end

    // State and output registers with asynchronous reset to the idle values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            phi_inc_q     <= {PHI_W{1'b0}};
            freq_mod_q    <= {PHI_W{1'b0}};
            nco_reset_n_q <= 1'b0;
            clken_q       <= 1'b0;
            busy_q        <= 1'b0;
            locked_q      <= 1'b0;
            fail_q        <= 1'b0;
            step_cnt_q    <= 8'd0;
            f_step_q      <= {PHI_W{1'b0}};
            f_stop_q      <= {PHI_W{1'b0}};
            dwell_q       <= DWELL_W'(1'b1);
            dwell_cnt_q   <= {DWELL_W{1'b0}};
            lock_cnt_q    <= {LCK_W{1'b0}};
            rst_cnt_q     <= {RST_W{1'b0}};
            vto_cnt_q     <= {VTO_W{1'b0}};
        end else begin
            state_q       <= state_d;
            phi_inc_q     <= phi_inc_d;
            freq_mod_q    <= freq_mod_d;
            nco_reset_n_q <= nco_reset_n_d;
            clken_q       <= clken_d;
            busy_q        <= busy_d;
            locked_q      <= locked_d;
            fail_q        <= fail_d;
            step_cnt_q    <= step_cnt_d;
            f_step_q      <= f_step_d;
            f_stop_q      <= f_stop_d;
            dwell_q       <= dwell_d;
            dwell_cnt_q   <= dwell_cnt_d;
            lock_cnt_q    <= lock_cnt_d;
            rst_cnt_q     <= rst_cnt_d;
            vto_cnt_q     <= vto_cnt_d;
        end
    end

    assign bus.nco_phi_inc_o  = phi_inc_q;
    assign bus.nco_freq_mod_o = freq_mod_q;
    assign bus.nco_reset_n_o  = nco_reset_n_q;
    assign bus.nco_clken_o    = clken_q;
    assign bus.busy_o         = busy_q;
    assign bus.locked_o       = locked_q;
    assign bus.fail_o         = fail_q;
    assign bus.step_cnt_o     = step_cnt_q;

endmodule

// File: tb/tb_nco_acq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_nco_acq_ctrl
// Directed bench for nco_acq_ctrl: a hand-written reset sequence followed by
// a table of {inputs, cycles to advance, expected outputs} records.
// Flags are packed as {nco_reset_n, clken, busy, locked, fail}.
// ----------------------------------------------------------------------------
module tb_nco_acq_ctrl;

    localparam logic [29:0] F_START = 30'h0400_0000;
    localparam logic [29:0] F_STEP  = 30'h0100_0000;
    localparam logic [29:0] F_STOP  = 30'h0700_0000;
    localparam logic [29:0] PHI5    = 30'h0500_0000;
    localparam logic [29:0] PHI6    = 30'h0600_0000;
    localparam logic [29:0] PHI7    = 30'h0700_0000;
    localparam logic [29:0] ERR_M5  = 30'h3FFF_FFFB;
    localparam logic [29:0] Z30     = 30'h0;

    localparam logic [4:0] FL_IDLE = 5'b00000;
    localparam logic [4:0] FL_RST  = 5'b01100;
    localparam logic [4:0] FL_RUN  = 5'b11100;
    localparam logic [4:0] FL_LOCK = 5'b11010;
    localparam logic [4:0] FL_FAIL = 5'b10001;

    typedef struct {
        string       name;
        int          adv;
        logic        st;
        logic        ab;
        logic        lk;
        logic        vl;
        logic [15:0] dw;
        logic [29:0] le;
        logic [29:0] e_phi;
        logic [29:0] e_fm;
        logic [4:0]  e_fl;
        logic [7:0]  e_step;
    } vec_t;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    vec_t vecs[$];

    nco_acq_ctrl_if #(.PHI_W(30), .DWELL_W(16)) bus ();

    nco_acq_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input string f, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s got=0x%0h expected=0x%0h", n, f, act, exp);
        end
    endtask

    task automatic chk_all(input string n, input logic [29:0] phi, input logic [29:0] fm,
                           input logic [4:0] fl, input logic [7:0] stp);
        chk(n, "phi_inc",  {2'b00, bus.nco_phi_inc_o}, {2'b00, phi});
        chk(n, "freq_mod", {2'b00, bus.nco_freq_mod_o}, {2'b00, fm});
        chk(n, "flags", {27'h0, bus.nco_reset_n_o, bus.nco_clken_o, bus.busy_o,
                         bus.locked_o, bus.fail_o}, {27'h0, fl});
        chk(n, "step_cnt", {24'h0, bus.step_cnt_o}, {24'h0, stp});
    endtask

    function automatic void add(string n, int adv, logic st, logic ab, logic lk, logic vl,
                                logic [15:0] dw, logic [29:0] le, logic [29:0] ephi,
                                logic [29:0] efm, logic [4:0] efl, logic [7:0] estep);
        vec_t v;
        v.name = n; v.adv = adv; v.st = st; v.ab = ab; v.lk = lk; v.vl = vl;
        v.dw = dw; v.le = le; v.e_phi = ephi; v.e_fm = efm; v.e_fl = efl; v.e_step = estep;
        vecs.push_back(v);
    endfunction

    initial begin
        errors = 0;
        checks = 0;

        // name, adv, start, abort, lock, valid, dwell, loop_err, phi, fm, flags, step
        // Sweep exhaust: 7 RST + 1 WAIT_V + 4x20 dwell + 4 STEP = fail after 92 edges.
        add("sw_start",     1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd20, Z30, F_START, Z30, FL_RST,  8'd0);
        add("sw_rst_low",   6, 1'b0, 1'b0, 1'b0, 1'b1, 16'd20, Z30, F_START, Z30, FL_RST,  8'd0);
        add("sw_rst_rise",  1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd20, Z30, F_START, Z30, FL_RUN,  8'd0);
        add("sw_dwell",     1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd20, Z30, F_START, Z30, FL_RUN,  8'd0);
        add("sw_ign_start",20, 1'b1, 1'b0, 1'b0, 1'b1, 16'd20, Z30, F_START, Z30, FL_RUN,  8'd0);
        add("sw_phi5",      1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd20, Z30, PHI5,    Z30, FL_RUN,  8'd1);
        add("sw_phi6",     21, 1'b0, 1'b0, 1'b0, 1'b1, 16'd20, Z30, PHI6,    Z30, FL_RUN,  8'd2);
        add("sw_phi7",     21, 1'b0, 1'b0, 1'b0, 1'b1, 16'd20, Z30, PHI7,    Z30, FL_RUN,  8'd3);
        add("sw_last_step",20, 1'b0, 1'b0, 1'b0, 1'b1, 16'd20, Z30, PHI7,    Z30, FL_RUN,  8'd3);
        add("sw_fail",      1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd20, Z30, PHI7,    Z30, FL_FAIL, 8'd3);
        add("fail_hold",    3, 1'b0, 1'b0, 1'b0, 1'b1, 16'd20, Z30, PHI7,    Z30, FL_FAIL, 8'd3);
        add("start_abort",  1, 1'b1, 1'b1, 1'b0, 1'b1, 16'd20, Z30, Z30,     Z30, FL_IDLE, 8'd0);
        add("idle_stay",    5, 1'b0, 1'b0, 1'b0, 1'b1, 16'd20, Z30, Z30,     Z30, FL_IDLE, 8'd0);
        // Acquire at step 2, freq_mod tracking, lock loss and resume.
        add("acq_start",    1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd20, Z30, F_START, Z30, FL_RST,  8'd0);
        add("acq_step2",   50, 1'b0, 1'b0, 1'b0, 1'b1, 16'd20, Z30, PHI6,    Z30, FL_RUN,  8'd2);
        add("acq_7high",    7, 1'b0, 1'b0, 1'b1, 1'b1, 16'd20, ERR_M5, PHI6, Z30, FL_RUN,  8'd2);
        add("acq_lock",     1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd20, ERR_M5, PHI6, ERR_M5, FL_LOCK, 8'd2);
        add("acq_fm_p3",    1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd20, 30'h3, PHI6, 30'h3, FL_LOCK, 8'd2);
        add("acq_fm_lag",   0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd20, 30'h7, PHI6, 30'h3, FL_LOCK, 8'd2);
        add("acq_fm_7",     1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd20, 30'h7, PHI6, 30'h7, FL_LOCK, 8'd2);
        add("loss_7",       7, 1'b0, 1'b0, 1'b0, 1'b1, 16'd20, 30'h7, PHI6, 30'h7, FL_LOCK, 8'd2);
        add("loss_clear",   1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd20, 30'h7, PHI6, 30'h7, FL_LOCK, 8'd2);
        add("loss_7b",      7, 1'b0, 1'b0, 1'b0, 1'b1, 16'd20, 30'h7, PHI6, 30'h7, FL_LOCK, 8'd2);
        add("loss_8",       1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd20, 30'h7, PHI6, Z30,   FL_RUN,  8'd2);
        add("resume_step", 20, 1'b0, 1'b0, 1'b0, 1'b1, 16'd20, 30'h7, PHI6, Z30,   FL_RUN,  8'd2);
        add("resume_phi7",  1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd20, 30'h7, PHI7, Z30,   FL_RUN,  8'd3);
        add("step_again",  20, 1'b0, 1'b0, 1'b0, 1'b1, 16'd20, 30'h7, PHI7, Z30,   FL_RUN,  8'd3);
        add("abort_step",   1, 1'b0, 1'b1, 1'b0, 1'b1, 16'd20, 30'h7, Z30,  Z30,   FL_IDLE, 8'd0);
        // NCO valid timeout: fail 64 cycles after nco_reset_n rises.
        add("to_start",     1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd20, Z30, F_START, Z30, FL_RST,  8'd0);
        add("to_rst_rise",  7, 1'b0, 1'b0, 1'b0, 1'b0, 16'd20, Z30, F_START, Z30, FL_RUN,  8'd0);
        add("to_wait",     63, 1'b0, 1'b0, 1'b0, 1'b0, 16'd20, Z30, F_START, Z30, FL_RUN,  8'd0);
        add("to_fail",      1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd20, Z30, F_START, Z30, FL_FAIL, 8'd0);
        // dwell_i = 0 behaves as one DWELL cycle per step (restart from FAIL).
        add("d0_start",     1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0,  Z30, F_START, Z30, FL_RST,  8'd0);
        add("d0_dwell",     8, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0,  Z30, F_START, Z30, FL_RUN,  8'd0);
        add("d0_step",      1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0,  Z30, F_START, Z30, FL_RUN,  8'd0);
        add("d0_phi5",      1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0,  Z30, PHI5,    Z30, FL_RUN,  8'd1);
        add("d0_phi7",      4, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0,  Z30, PHI7,    Z30, FL_RUN,  8'd3);
        add("d0_last",      1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0,  Z30, PHI7,    Z30, FL_RUN,  8'd3);
        add("d0_fail",      1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0,  Z30, PHI7,    Z30, FL_FAIL, 8'd3);

        reset           = 1'b1;
        bus.start_i     = 1'b0;
        bus.abort_i     = 1'b0;
        bus.f_start_i   = F_START;
        bus.f_step_i    = F_STEP;
        bus.f_stop_i    = F_STOP;
        bus.dwell_i     = 16'd20;
        bus.lock_i      = 1'b0;
        bus.loop_err_i  = Z30;
        bus.nco_valid_i = 1'b1;

        // Reset state, then asynchronous reset in the middle of a dwell.
        #1;
        chk_all("reset_state", Z30, Z30, FL_IDLE, 8'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        repeat (14) tick();
        chk_all("mid_dwell", F_START, Z30, FL_RUN, 8'd0);
        reset = 1'b1;
        #2;
        chk_all("async_reset", Z30, Z30, FL_IDLE, 8'd0);
        tick();
        reset = 1'b0;
        repeat (10) tick();
        chk_all("idle_after_reset", Z30, Z30, FL_IDLE, 8'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            bus.start_i     = vecs[i].st;
            bus.abort_i     = vecs[i].ab;
            bus.lock_i      = vecs[i].lk;
            bus.nco_valid_i = vecs[i].vl;
            bus.dwell_i     = vecs[i].dw;
            bus.loop_err_i  = vecs[i].le;
            if (vecs[i].adv > 0) begin
                tick();
                bus.start_i = 1'b0;
                bus.abort_i = 1'b0;
                for (int c = 1; c < vecs[i].adv; c++) begin
                    tick();
                end
            end else begin
                #1;
            end
            chk_all(vecs[i].name, vecs[i].e_phi, vecs[i].e_fm, vecs[i].e_fl, vecs[i].e_step);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nco_acq_ctrl.md
# nco_acq_ctrl

Carrier-acquisition controller for the BPSK receive NCO. It sequences the NCO through reset and start-up, and steps its phase increment across a programmed frequency window. It dwells at each step waiting for the carrier loop to report lock. Once locked, it hands fine frequency control to the loop error via the NCO's frequency-modulation input, and it re-acquires if lock is lost.

## Interface
Parameters:
- PHI_W, 30, NCO phase-increment / freq-mod width
- DWELL_W, 16, width of dwell counter and `dwell_i`
- RST_CYC, 7, cycles `nco_reset_n_o` is held low on each start
- VALID_TO, 64, max cycles to wait for `nco_valid_i` after NCO reset release
- LOCK_CNT, 8, consecutive cycles of `lock_i` high to declare lock, and of `lock_i` low to declare loss

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- start_i  in  1  one-cycle start pulse
- abort_i  in  1  return to IDLE
- f_start_i  in  PHI_W  first phase increment (unsigned)
- f_step_i  in  PHI_W  increment added per step (unsigned)
- f_stop_i  in  PHI_W  last allowed phase increment (unsigned)
- dwell_i  in  DWELL_W  cycles spent per step; 0 treated as 1
- lock_i  in  1  carrier-loop lock indicator
- loop_err_i  in  PHI_W  signed loop frequency correction
- nco_valid_i  in  1  NCO out_valid
- nco_phi_inc_o  out  PHI_W  NCO phase increment
- nco_freq_mod_o  out  PHI_W  NCO frequency modulation
- nco_reset_n_o  out  1  NCO active-low reset
- nco_clken_o  out  1  NCO clock enable
- busy_o  out  1  acquisition in progress
- locked_o  out  1  carrier locked
- fail_o  out  1  window exhausted or NCO start-up timeout
- step_cnt_o  out  8  index of current step, saturating at 255

## Operation
- All outputs are registered. Reset values:
  - phi_inc = 0, freq_mod = 0, nco_reset_n = 0, clken = 0
  - busy, locked, fail = 0; step_cnt = 0; state = IDLE
- **IDLE**: nco_reset_n = 0, clken = 0.
  - On `start_i`, latch `f_step_i`, `f_stop_i`, `dwell_i`; set phi_inc = `f_start_i`, step_cnt = 0, busy = 1, fail = 0, locked = 0; go to RST.
- **RST**: clken = 1, nco_reset_n = 0 for exactly RST_CYC cycles, then nco_reset_n = 1; go to WAIT_V.
- **WAIT_V**:
  - `nco_valid_i` = 1 → DWELL; clear dwell and lock counters.
  - VALID_TO cycles elapse without it → FAIL.
- **DWELL**: the dwell counter increments every cycle. The lock counter increments while `lock_i` = 1 and clears when `lock_i` = 0.
  - Lock counter reaches LOCK_CNT → LOCKED.
  - Otherwise, when the dwell counter reaches the latched dwell value (min 1) → STEP.
  - If both conditions occur in the same cycle, lock wins.
- **STEP** (1 cycle): compute next = phi_inc + step at PHI_W+1 bits.
  - If next > f_stop, or a carry occurs → FAIL; phi_inc is held.
  - Else phi_inc = next, step_cnt += 1 (saturating), counters clear → DWELL.
  - The NCO is not reset; phase stays continuous.
- **LOCKED**: locked = 1, busy = 0, freq_mod = registered `loop_err_i` each cycle.
  - `lock_i` low for LOCK_CNT consecutive cycles → freq_mod = 0, locked = 0, busy = 1, counters clear → DWELL at the current phi_inc.
  - A high cycle clears the loss counter.
- **FAIL**: fail = 1, busy = 0, clken = 0, nco_reset_n = 1, phi_inc held.
- Restart and abort:
  - `start_i` in IDLE, LOCKED or FAIL restarts as from IDLE. `start_i` is ignored in RST, WAIT_V, DWELL and STEP.
  - `abort_i` in any state → IDLE next cycle with all outputs at reset values. `abort_i` has priority over `start_i`.
- freq_mod = 0 in every state except LOCKED.
- Asynchronous `reset` mid-operation forces reset values immediately; there is no resume.

## Timing
- `start_i` at edge N: nco_reset_n = 0 and clken = 1 from N+1; nco_reset_n rises at N+1+RST_CYC.
- WAIT_V → DWELL transition: one cycle after `nco_valid_i` is sampled high.
- Dwell per step: exactly max(dwell, 1) cycles in DWELL, plus 1 STEP cycle.
- Lock detect: locked_o rises 1 cycle after the LOCK_CNT-th consecutive high sample. The LOCK_CNT samples must all be taken within DWELL.
- freq_mod: 1 cycle latency from `loop_err_i`.
- Fail: fail_o rises 1 cycle after the STEP cycle or after the timeout.

## Test plan
- **Reset:** assert `reset` mid-DWELL → all outputs return to reset values at once. After release, the block stays in IDLE until `start_i`.
- **Sweep exhaust:** f_start = 0x0400_0000, f_step = 0x0100_0000, f_stop = 0x0700_0000, dwell = 20, `lock_i` = 0, `nco_valid_i` tied to 1.
  - phi_inc must visit 0x04, 0x05, 0x06, 0x07 (×2^24).
  - fail_o = 1 with step_cnt = 3 and phi_inc = 0x0700_0000.
  - Expected cycle count is 7 RST + 1 WAIT_V + 80 dwell + 4 STEP; the bench checks it exactly.
- **Acquire:** same config, `lock_i` = 1 from the start of step 2.
  - locked_o = 1 after 8 cycles with phi_inc = 0x0600_0000 and busy = 0.
  - nco_freq_mod_o tracks `loop_err_i` (−5, +3) with 1-cycle lag.
- **Lock loss:**
  - In LOCKED, drop `lock_i` for 7 cycles → locked_o stays 1.
  - Then drop it for 8 cycles → locked_o = 0, freq_mod = 0, DWELL resumes at the same phi_inc.
- **NCO timeout:** `nco_valid_i` = 0 → fail_o rises 64 cycles after nco_reset_n rises.
- **Abort:**
  - `abort_i` during STEP → IDLE next cycle, outputs at reset values.
  - Simultaneous `start_i` + `abort_i` in FAIL → IDLE.
  - `dwell_i` = 0 run → one DWELL cycle per step.
